// File: rtl/serial_pkg.sv
// serial_pkg: line levels, FSM states and parity helper shared by the serial transmitter and receiver.
package serial_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // Zero-extending narrower words to 16 bits does not change their parity.
    function automatic logic odd_parity(input logic [15:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// serial_bit_timer: counts 0..CLKS_PER_BIT-1 and flags the final clk of each bit period.
module serial_bit_timer #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic bit_end
);

    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] cnt;

    assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);

    always_ff @(posedge clk) begin
        if (reset || restart)
            cnt <= '0;
        else
            cnt <= bit_end ? '0 : cnt + CW'(1);
    end

endmodule

// File: rtl/serial_tx_framer.sv
// serial_tx_framer: turns accepted parallel words into start/data/parity/stop frames on an idle-high line.
module serial_tx_framer
    import serial_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 1,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 txd,
    output logic                 busy,
    output logic                 done
);

    localparam int IW = $clog2(DATA_BITS + 1);

    state_t               state, state_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [IW-1:0]        idx, idx_n;
    logic                 par, par_n, txd_n;
    logic                 bit_end, accept, last_stop, last_data;

    serial_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .restart (state == IDLE),
        .bit_end (bit_end)
    );

    assign last_stop = state == STOP && bit_end && idx == IW'(STOP_BITS - 1);
    assign last_data = idx == IW'(DATA_BITS - 1);
    assign in_ready  = state == IDLE || last_stop;
    assign accept    = in_valid && in_ready;
    assign busy      = state != IDLE;
    assign done      = last_stop;

    // idx counts data bits in DATA and stop periods in STOP; it is cleared on every state change.
    always_comb begin
        state_n = state;
        shift_n = shift;
        idx_n   = idx;
        par_n   = par;
        if (accept) begin
            state_n = START;
            shift_n = in_data;
            par_n   = odd_parity(16'(in_data));
            idx_n   = '0;
        end else if (bit_end) begin
            case (state)
                START:  state_n = DATA;
                DATA: begin
                    shift_n = shift >> 1;
                    idx_n   = last_data ? '0 : idx + IW'(1);
                    state_n = !last_data ? DATA : PARITY_EN != 0 ? PARITY : STOP;
                end
                PARITY: state_n = STOP;
                STOP: begin
                    idx_n   = last_stop ? '0 : idx + IW'(1);
                    state_n = last_stop ? IDLE : STOP;
                end
                default: state_n = state;
            endcase
        end
        txd_n = state_n == START  ? START_BIT :
                state_n == DATA   ? shift_n[0] :
                state_n == PARITY ? par_n :
                state_n == STOP   ? STOP_BIT : IDLE_LEVEL;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            shift <= '0;
            idx   <= '0;
            par   <= 1'b0;
            txd   <= IDLE_LEVEL;
        end else begin
            state <= state_n;
            shift <= shift_n;
            idx   <= idx_n;
            par   <= par_n;
            txd   <= txd_n;
        end
    end

endmodule

// File: tb/tb_serial_tx_framer.sv
// tb_serial_tx_framer: scoreboard bench driving a default framer and a 3-clk/no-parity/2-stop framer.
module tb_serial_tx_framer;

    typedef struct packed {
        logic txd;
        logic last;
    } item_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data [2];
    logic       in_valid [2];
    logic       in_ready [2];
    logic       txd [2];
    logic       busy [2];
    logic       done [2];

    item_t q0[$];
    item_t q1[$];
    bit    fresh [2];
    bit    started = 1'b0;
    int    tests = 0;
    int    fails = 0;

    always #5 clk = ~clk;

    serial_tx_framer #(.DATA_BITS(8), .PARITY_EN(1), .STOP_BITS(1), .CLKS_PER_BIT(1)) dut0 (
        .clk(clk), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .txd(txd[0]), .busy(busy[0]), .done(done[0])
    );

    serial_tx_framer #(.DATA_BITS(8), .PARITY_EN(0), .STOP_BITS(2), .CLKS_PER_BIT(3)) dut1 (
        .clk(clk), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .txd(txd[1]), .busy(busy[1]), .done(done[1])
    );

    function automatic int cpb(int i); return i != 0 ? 3 : 1; endfunction
    function automatic int pe(int i);  return i != 0 ? 0 : 1; endfunction
    function automatic int sb(int i);  return i != 0 ? 2 : 1; endfunction
    function automatic int qsize(int i); return i != 0 ? q1.size() : q0.size(); endfunction

    task automatic chk(string name, int i, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[dut%0d] at %0t: got %0h expected %0h", name, i, $time, act, exp);
        end
    endtask

    // Expected line level for every clk of the frame, the final clk flagged for done.
    task automatic push_frame(int i, logic [7:0] d);
        logic  b[$];
        item_t it;
        b.push_back(1'b0);
        for (int k = 0; k < 8; k++) b.push_back(d[k]);
        if (pe(i) != 0) b.push_back(($countones(d) % 2) == 0);
        for (int k = 0; k < sb(i); k++) b.push_back(1'b1);
        if (qsize(i) == 0) fresh[i] = 1'b1;
        for (int j = 0; j < b.size(); j++)
            for (int c = 0; c < cpb(i); c++) begin
                it.txd  = b[j];
                it.last = (j == b.size() - 1) && (c == cpb(i) - 1);
                if (i != 0) q1.push_back(it); else q0.push_back(it);
            end
    endtask

    // Ready is expected when nothing, or only the final stop clk, is left to send.
    task automatic step(int i, logic v, logic [7:0] d, output bit acc);
        bit rdy;
        rdy = qsize(i) <= 1;
        in_valid[i] = v;
        in_data[i]  = d;
        chk("in_ready", i, 32'(in_ready[i]), 32'(rdy));
        acc = v && rdy;
        if (acc) push_frame(i, d);
        @(posedge clk);
        #1;
        in_valid[i] = 1'b0;
    endtask

    task automatic xfer(int i, logic [7:0] d);
        bit a = 1'b0;
        for (int n = 0; n < 100 && !a; n++) step(i, 1'b1, d, a);
    endtask

    task automatic idle(int i, int n);
        bit a;
        for (int k = 0; k < n; k++) step(i, 1'b0, 8'h00, a);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid[0] = 1'b0;
        in_valid[1] = 1'b0;
        @(posedge clk);
        #1;
        q0.delete();
        q1.delete();
        fresh[0] = 1'b0;
        fresh[1] = 1'b0;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (started && !reset) begin
            for (int i = 0; i < 2; i++) begin
                bit    eb;
                item_t it;
                eb = qsize(i) > 0 && !fresh[i];
                fresh[i] = 1'b0;
                chk("busy", i, 32'(busy[i]), 32'(eb));
                if (eb) begin
                    it = i != 0 ? q1.pop_front() : q0.pop_front();
                    chk("txd", i, 32'(txd[i]), 32'(it.txd));
                    chk("done", i, 32'(done[i]), 32'(it.last));
                end else begin
                    chk("txd_idle", i, 32'(txd[i]), 32'd1);
                    chk("done_idle", i, 32'(done[i]), 32'd0);
                end
            end
        end
    end

    initial begin
        bit a;
        in_valid[0] = 1'b0;
        in_valid[1] = 1'b0;
        in_data[0]  = 8'h00;
        in_data[1]  = 8'h00;
        fresh[0]    = 1'b0;
        fresh[1]    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        started = 1'b1;
        xfer(0, 8'h5A);
        idle(0, 14);
        xfer(0, 8'hFF);
        xfer(0, 8'h01);
        idle(0, 14);
        xfer(0, 8'h5A);
        idle(0, 4);
        do_reset();
        xfer(0, 8'h3C);
        idle(0, 13);
        xfer(0, 8'h5A);
        for (int k = 0; k < 9; k++) step(0, 1'($urandom_range(0, 1)), 8'($urandom), a);
        idle(0, 4);
        xfer(1, 8'hA5);
        idle(1, 36);
        xfer(1, 8'h3C);
        xfer(1, 8'hC3);
        idle(1, 70);
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) do_reset();
            step(int'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 8'($urandom), a);
        end
        idle(0, 40);
        idle(1, 40);
        chk("drain", 0, 32'(q0.size()), 32'd0);
        chk("drain", 1, 32'(q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
